// File: rtl/add_stream_stager.sv
// Narrow valid/ready bridge around a wide combinational adder: loads A and B in
// BEAT_W-bit beats, captures sum/carry for one cycle, then streams the result back out.
module add_stream_stager #(
    parameter int WIDTH  = 100,
    parameter int BEAT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    output logic              out_cout,
    output logic [WIDTH-1:0]  add_a,
    output logic [WIDTH-1:0]  add_b,
    output logic              add_cin,
    input  logic [WIDTH-1:0]  add_sum,
    input  logic              add_cout
);

    localparam int BEATS  = (WIDTH + BEAT_W - 1) / BEAT_W;
    localparam int LAST_W = WIDTH - (BEATS - 1) * BEAT_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        EVAL,
        SEND
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result;
    logic             cin_reg;
    logic             cout_reg;

    logic             load_a;
    logic             load_b;
    logic             capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD_A;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        capture    = 1'b0;
        case (state)
            LOAD_A, LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_a = (state == LOAD_A);
                    load_b = (state == LOAD_B);
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = (state == LOAD_A) ? LOAD_B : EVAL;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            EVAL: begin
                capture    = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (cnt == CNT_LAST);
                if (out_ready) begin
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = LOAD_A;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = LOAD_A;
            end
        endcase
    end

    // The top beat only carries LAST_W meaningful bits; anything above is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            cin_reg  <= 1'b0;
            result   <= '0;
            cout_reg <= 1'b0;
        end else begin
            if (load_a) begin
                if (cnt == '0) begin
                    cin_reg <= in_cin;
                end
                for (int i = 0; i < BEATS - 1; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        a_reg[i*BEAT_W +: BEAT_W] <= in_data;
                    end
                end
                if (cnt == CNT_LAST) begin
                    a_reg[WIDTH-1 -: LAST_W] <= in_data[LAST_W-1:0];
                end
            end
            if (load_b) begin
                for (int i = 0; i < BEATS - 1; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        b_reg[i*BEAT_W +: BEAT_W] <= in_data;
                    end
                end
                if (cnt == CNT_LAST) begin
                    b_reg[WIDTH-1 -: LAST_W] <= in_data[LAST_W-1:0];
                end
            end
            if (capture) begin
                result   <= add_sum;
                cout_reg <= add_cout;
            end
        end
    end

    always_comb begin
        out_data = '0;
        out_cout = 1'b0;
        if (state == SEND) begin
            out_cout = cout_reg;
            for (int i = 0; i < BEATS - 1; i++) begin
                if (cnt == CNT_W'(i)) begin
                    out_data = result[i*BEAT_W +: BEAT_W];
                end
            end
            if (cnt == CNT_LAST) begin
                out_data = BEAT_W'(result[WIDTH-1 -: LAST_W]);
            end
        end
    end

    assign add_a   = a_reg;
    assign add_b   = b_reg;
    assign add_cin = cin_reg;

endmodule

// File: tb/tb_add_stream_stager.sv
// Bench for add_stream_stager: a behavioural adder sits beside the DUT, directed vectors
// come from a table, and random transactions are checked against plain 101-bit arithmetic.
module tb_add_stream_stager;

    localparam int WIDTH  = 100;
    localparam int BEAT_W = 32;
    localparam int BEATS  = 4;
    localparam int BUDGET = 100;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data;
    logic              in_cin;
    logic              out_valid;
    logic              out_ready;
    logic [BEAT_W-1:0] out_data;
    logic              out_last;
    logic              out_cout;
    logic [WIDTH-1:0]  add_a;
    logic [WIDTH-1:0]  add_b;
    logic              add_cin;
    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         cin;
        logic [127:0] exp;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[5];

    add_stream_stager #(.WIDTH(WIDTH), .BEAT_W(BEAT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // The wide adder the stager drives.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_beat(input logic [BEAT_W-1:0] d, input logic c, input int gap);
        int waited;
        waited = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        while (!in_ready && waited < BUDGET) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL in_ready_timeout: got 0 expected 1 within %0d cycles", BUDGET);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Loads A then B; in_cin carries junk on every beat except A beat 0.
    task automatic apply_stimulus(input logic [127:0] a, input logic [127:0] b,
                                  input logic cin, input bit rand_gaps);
        int gap;
        for (int i = 0; i < BEATS; i++) begin
            gap = (rand_gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            send_beat(a[i*BEAT_W +: BEAT_W], (i == 0) ? cin : 1'($urandom), gap);
        end
        for (int i = 0; i < BEATS; i++) begin
            gap = (rand_gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            send_beat(b[i*BEAT_W +: BEAT_W], 1'($urandom), gap);
        end
        check_output("add_a", 128'(add_a), 128'(a[WIDTH-1:0]));
        check_output("add_b", 128'(add_b), 128'(b[WIDTH-1:0]));
        check_output("add_cin", 128'(add_cin), 128'(cin));
        check_output("eval_idle", 128'({in_ready, out_valid}), 128'(0));
        // A source holding a beat during EVAL/SEND must not have it taken.
        in_valid = 1'b1;
        in_data  = $urandom;
    endtask

    task automatic collect_result(input logic [127:0] exp, input logic exp_cout,
                                  input int hold, input bit rand_ready);
        int  waited;
        int  held;
        bit  done;
        for (int k = 0; k < BEATS; k++) begin
            waited = 0;
            held   = 0;
            done   = 1'b0;
            while (!done) begin
                if (hold > 0)        out_ready = (held >= hold);
                else if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
                else                 out_ready = 1'b1;
                if (out_valid) begin
                    check_output($sformatf("out_data[%0d]", k), 128'(out_data),
                                 128'(exp[k*BEAT_W +: BEAT_W]));
                    check_output($sformatf("out_last[%0d]", k), 128'(out_last),
                                 128'(k == BEATS - 1));
                    check_output($sformatf("out_cout[%0d]", k), 128'(out_cout), 128'(exp_cout));
                    check_output("in_ready_in_send", 128'(in_ready), 128'(0));
                    if (out_ready) done = 1'b1;
                    held++;
                end else begin
                    waited++;
                    if (waited > BUDGET) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL out_valid_timeout: beat %0d got 0 expected 1", k);
                        out_ready = 1'b0;
                        in_valid  = 1'b0;
                        return;
                    end
                end
                @(posedge clk);
                #1;
            end
            if (k == BEATS - 1) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_output("no_extra_beat", 128'(out_valid), 128'(0));
        check_output("ready_after_send", 128'(in_ready), 128'(1));
    endtask

    function automatic logic [128:0] model(input logic [127:0] a, input logic [127:0] b,
                                           input logic cin);
        logic [WIDTH:0] s;
        s = {1'b0, a[WIDTH-1:0]} + {1'b0, b[WIDTH-1:0]} + (WIDTH+1)'(cin);
        return {s[WIDTH], 128'(s[WIDTH-1:0])};
    endfunction

    initial begin
        logic [127:0] ra;
        logic [127:0] rb;
        logic         rc;
        logic [128:0] m;

        vecs[0] = '{a: 128'h1, b: 128'h2, cin: 1'b0, exp: 128'h3, exp_cout: 1'b0};
        vecs[1] = '{a: 128'h0000000F_FFFFFFFF_FFFFFFFF_FFFFFFFF, b: 128'h0, cin: 1'b1,
                    exp: 128'h0, exp_cout: 1'b1};
        vecs[2] = '{a: 128'hFFFFFFF0_00000000_00000000_00000000, b: 128'h0, cin: 1'b0,
                    exp: 128'h0, exp_cout: 1'b0};
        vecs[3] = '{a: 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, b: 128'h1, cin: 1'b0,
                    exp: 128'h0, exp_cout: 1'b1};
        vecs[4] = '{a: 128'hFFFFFFFF, b: 128'h1, cin: 1'b0,
                    exp: 128'h00000000_00000000_00000001_00000000, exp_cout: 1'b0};

        in_data = '0;
        in_cin  = 1'b0;
        do_reset();
        check_output("reset_in_ready", 128'(in_ready), 128'(1));
        check_output("reset_out_valid", 128'(out_valid), 128'(0));
        check_output("reset_out_last", 128'(out_last), 128'(0));
        check_output("reset_out_data", 128'(out_data), 128'(0));
        check_output("reset_out_cout", 128'(out_cout), 128'(0));
        check_output("reset_add_a", 128'(add_a), 128'(0));

        for (int v = 0; v < 5; v++) begin
            apply_stimulus(vecs[v].a, vecs[v].b, vecs[v].cin, 1'b0);
            collect_result(vecs[v].exp, vecs[v].exp_cout, 0, 1'b0);
        end

        $display("[TB] backpressure: out_ready low 5 cycles per beat");
        apply_stimulus(vecs[0].a, vecs[0].b, vecs[0].cin, 1'b0);
        collect_result(vecs[0].exp, vecs[0].exp_cout, 5, 1'b0);

        $display("[TB] reset after two A beats");
        send_beat(32'h0000_0055, 1'b1, 0);
        send_beat(32'h0000_0077, 1'b0, 0);
        do_reset();
        check_output("midreset_in_ready", 128'(in_ready), 128'(1));
        check_output("midreset_out_valid", 128'(out_valid), 128'(0));
        check_output("midreset_add_a", 128'(add_a), 128'(0));
        check_output("midreset_add_cin", 128'(add_cin), 128'(0));
        apply_stimulus(vecs[0].a, vecs[0].b, vecs[0].cin, 1'b0);
        collect_result(vecs[0].exp, vecs[0].exp_cout, 0, 1'b0);

        $display("[TB] random transactions");
        for (int t = 0; t < 1000; t++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rc = 1'($urandom);
            if (t % 10 == 0) begin
                ra = '1;
                rb = {96'h0, $urandom};
            end
            m = model(ra, rb, rc);
            apply_stimulus(ra, rb, rc, 1'b1);
            collect_result(m[127:0], m[128], 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
